// File: rtl/if_fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, addresses the instruction ROM and fills IF/ID.
// Define IF_FETCH_PERF_EN to add the perf_cycles / perf_fetched / perf_stalls counters.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          IMEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
`endif
    output logic        fault
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_SIZE);

    state_t      state;
    logic [63:0] pc;

    // Last byte of a word is addr+3; kept in 65 bits so the top of the address space cannot wrap into range.
    logic [64:0] pc_last;
    logic [64:0] redirect_last;
    logic        pc_oob;
    logic        redirect_oob;
    logic        redirect_misaligned;
    logic        fetch_en;

    assign pc_last             = {1'b0, pc} + 65'd3;
    assign redirect_last       = {1'b0, redirect_pc} + 65'd3;
    assign pc_oob              = (pc_last >= IMEM_LIMIT);
    assign redirect_oob        = (redirect_last >= IMEM_LIMIT);
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    assign fetch_en            = (state == RUN) && !redirect_valid && !stall && !pc_oob;

    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign fault     = (state == FAULT);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_pc    <= 64'd0;
            if_id_instr <= 32'd0;
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                RUN, HALT: begin
                    if (redirect_valid) begin
                        // Whatever was fetched this cycle is wrong-path.
                        if_id_pc    <= 64'd0;
                        if_id_instr <= 32'd0;
                        if_id_valid <= 1'b0;
                        if (redirect_misaligned) begin
                            state <= FAULT;
                        end else begin
                            pc    <= redirect_pc;
                            state <= redirect_oob ? HALT : RUN;
                        end
                    end else if (state == RUN) begin
                        if (pc_oob) begin
                            state       <= HALT;
                            if_id_valid <= 1'b0;
                        end else if (!stall) begin
                            if_id_pc    <= pc;
                            if_id_instr <= imem_instr;
                            if_id_valid <= 1'b1;
                            pc          <= pc + 64'd4;
                        end
                    end
                end
                default: begin
                    // FAULT (and any illegal encoding) is frozen until reset.
                    if_id_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_cycles  <= 32'd0;
            perf_fetched <= 32'd0;
            perf_stalls  <= 32'd0;
        end else if (state != FAULT) begin
            perf_cycles <= perf_cycles + 32'd1;
            if (fetch_en)
                perf_fetched <= perf_fetched + 32'd1;
            if (state == RUN && stall && !redirect_valid)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage with a small ROM model and a bounded end-of-program run.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        fault;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch_stage #(.RESET_PC(64'd0), .IMEM_SIZE(1024)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
`ifdef IF_FETCH_PERF_EN
        .perf_cycles    (perf_cycles),
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls),
`endif
        .fault          (fault)
    );

    always #5 clk = ~clk;

    // ROM: two real instructions at 0 and 4, elsewhere a tag word 0xD500_xxxx carrying the address.
    function automatic logic [31:0] rom(input logic [63:0] a);
        if (a == 64'd0) return 32'h9100_0421;
        if (a == 64'd4) return 32'h9100_0842;
        return 32'hD500_0000 | {16'd0, a[15:0]};
    endfunction

    assign imem_instr = rom(imem_addr);

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic [63:0] e_addr;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_v;
        logic        e_h;
        logic        e_f;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic s, input logic rv, input logic [63:0] rp,
                       input logic [63:0] ea, input logic [63:0] ep, input logic [31:0] ei,
                       input logic ev, input logic eh, input logic ef);
        vec_t v;
        v.rst_n = r; v.stall = s; v.redir = rv; v.rpc = rp;
        v.e_addr = ea; v.e_pc = ep; v.e_instr = ei; v.e_v = ev; v.e_h = eh; v.e_f = ef;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic rv, input logic [63:0] rp);
        reset_n = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fetched;
        int waited;
        reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;

        //   rst stl rdr rpc            addr          if_id_pc      instr         v h f
        add(0, 0, 0, 64'h0,           64'h0,        64'h0,        32'h0,        0,0,0);
        add(0, 0, 0, 64'h0,           64'h0,        64'h0,        32'h0,        0,0,0);
        add(1, 0, 0, 64'h0,           64'h4,        64'h0,        32'h91000421, 1,0,0);
        add(1, 0, 0, 64'h0,           64'h8,        64'h4,        32'h91000842, 1,0,0);
        add(1, 1, 0, 64'h0,           64'h8,        64'h4,        32'h91000842, 1,0,0);
        add(1, 1, 0, 64'h0,           64'h8,        64'h4,        32'h91000842, 1,0,0);
        add(1, 1, 0, 64'h0,           64'h8,        64'h4,        32'h91000842, 1,0,0);
        add(1, 0, 0, 64'h0,           64'hC,        64'h8,        32'hD5000008, 1,0,0);
        add(1, 0, 0, 64'h0,           64'h10,       64'hC,        32'hD500000C, 1,0,0);
        add(1, 1, 1, 64'h40,          64'h40,       64'h0,        32'h0,        0,0,0);
        add(1, 0, 0, 64'h0,           64'h44,       64'h40,       32'hD5000040, 1,0,0);
        add(1, 0, 1, 64'h3F8,         64'h3F8,      64'h0,        32'h0,        0,0,0);
        add(1, 0, 0, 64'h0,           64'h3FC,      64'h3F8,      32'hD50003F8, 1,0,0);
        add(1, 0, 0, 64'h0,           64'h400,      64'h3FC,      32'hD50003FC, 1,0,0);
        add(1, 0, 0, 64'h0,           64'h400,      64'h3FC,      32'hD50003FC, 0,1,0);
        add(1, 1, 0, 64'h0,           64'h400,      64'h3FC,      32'hD50003FC, 0,1,0);
        add(1, 0, 1, 64'h20,          64'h20,       64'h0,        32'h0,        0,0,0);
        add(1, 0, 0, 64'h0,           64'h24,       64'h20,       32'hD5000020, 1,0,0);
        add(1, 0, 1, 64'h22,          64'h24,       64'h0,        32'h0,        0,0,1);
        add(1, 0, 1, 64'h40,          64'h24,       64'h0,        32'h0,        0,0,1);
        add(1, 1, 0, 64'h0,           64'h24,       64'h0,        32'h0,        0,0,1);
        add(0, 0, 0, 64'h0,           64'h0,        64'h0,        32'h0,        0,0,0);
        add(1, 0, 0, 64'h0,           64'h4,        64'h0,        32'h91000421, 1,0,0);
        add(1, 1, 0, 64'h0,           64'h4,        64'h0,        32'h91000421, 1,0,0);
        add(0, 1, 0, 64'h0,           64'h0,        64'h0,        32'h0,        0,0,0);
        add(1, 0, 1, 64'h3FC,         64'h3FC,      64'h0,        32'h0,        0,0,0);
        add(1, 0, 0, 64'h0,           64'h400,      64'h3FC,      32'hD50003FC, 1,0,0);
        add(1, 1, 0, 64'h0,           64'h400,      64'h3FC,      32'hD50003FC, 0,1,0);
        add(1, 0, 1, 64'h800,         64'h800,      64'h0,        32'h0,        0,1,0);
        add(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0, 0,1,0);
        add(1, 0, 1, 64'h0,           64'h0,        64'h0,        32'h0,        0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            check($sformatf("v%0d imem_addr", i),   imem_addr,   vecs[i].e_addr);
            check($sformatf("v%0d if_id_pc", i),    if_id_pc,    vecs[i].e_pc);
            check($sformatf("v%0d if_id_instr", i), {32'd0, if_id_instr}, {32'd0, vecs[i].e_instr});
            check($sformatf("v%0d if_id_valid", i), {63'd0, if_id_valid}, {63'd0, vecs[i].e_v});
            check($sformatf("v%0d halted", i),      {63'd0, halted},      {63'd0, vecs[i].e_h});
            check($sformatf("v%0d fault", i),       {63'd0, fault},       {63'd0, vecs[i].e_f});
        end

        // Run off the end of the ROM from 0x3F0: exactly four fetches, then halt at 0x400.
        drive(1, 0, 1, 64'h3F0);
        fetched = 0;
        waited  = 0;
        while (!halted && waited < 20) begin
            drive(1, 0, 0, 64'h0);
            if (if_id_valid) fetched++;
            waited++;
        end
        check("eop halted", {63'd0, halted}, 64'd1);
        check("eop fetches", 64'(fetched), 64'd4);
        check("eop imem_addr", imem_addr, 64'h400);
        check("eop last pc", if_id_pc, 64'h3FC);

`ifdef IF_FETCH_PERF_EN
        drive(0, 0, 0, 64'h0);
        check("perf reset cycles", {32'd0, perf_cycles}, 64'd0);
        check("perf reset fetched", {32'd0, perf_fetched}, 64'd0);
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 64'h0);
        check("perf fetched 5", {32'd0, perf_fetched}, 64'd5);
        drive(1, 1, 0, 64'h0);
        drive(1, 1, 0, 64'h0);
        check("perf stalls 2", {32'd0, perf_stalls}, 64'd2);
        check("perf cycles 7", {32'd0, perf_cycles}, 64'd7);
        drive(1, 0, 1, 64'h22);
        drive(1, 0, 0, 64'h0);
        drive(1, 1, 0, 64'h0);
        check("perf cycles frozen", {32'd0, perf_cycles}, 64'd8);
        check("perf fetched frozen", {32'd0, perf_fetched}, 64'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
